// File: rtl/powerup_manager_pkg.sv
// Shared constants and types for the gift / powerup logic.
package powerup_manager_pkg;

    // Gift type bit as delivered by the gift block.
    localparam logic POWERUP_TYPE_SHIELD = 1'b0;  // blue gift
    localparam logic POWERUP_TYPE_RAPID  = 1'b1;  // red gift

    // Default powerup timing, in frames (60 Hz).
    localparam int unsigned GIFT_POWERUP_FRAMES = 600;  // 10 s effect
    localparam int unsigned GIFT_WARN_FRAMES    = 120;  // last 2 s blink
    localparam int unsigned GIFT_BLINK_LOG2     = 3;    // toggle every 8 frames
    localparam int unsigned GIFT_CNT_WIDTH      = 10;

    // Powerup effect state.
    typedef enum logic [1:0] {
        PU_IDLE   = 2'd0,
        PU_ACTIVE = 2'd1,
        PU_WARN   = 2'd2
    } pu_state_t;

endpackage

// File: rtl/powerup_manager_frame_down_counter.sv
// Frame-counted down counter: loadable, decrements on a qualified strobe,
// never wraps below zero. The flags describe the value the counter would
// hold after a decrement, so a controller can pick its next state in the
// same cycle it requests the decrement.
module frame_down_counter #(
    parameter int unsigned CNT_WIDTH = 10,
    parameter int unsigned THRESHOLD = 120
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_value,
    input  logic                 i_dec,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_zero,
    output logic                 o_dec_zero,
    output logic                 o_dec_le_thresh
);

    localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(THRESHOLD);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_dec;
    logic                 w_dec_ok;

    assign w_count_dec = r_count - 1'b1;
    // Decrement is refused at zero so the counter can never wrap.
    assign w_dec_ok    = i_dec & (r_count != '0);

    // Count register: load has priority over decrement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (w_dec_ok) begin
            r_count <= w_count_dec;
        end
    end

    assign o_count         = r_count;
    assign o_zero          = (r_count == '0);
    assign o_dec_zero      = (r_count == CNT_WIDTH'(1));
    assign o_dec_le_thresh = (w_count_dec <= THRESH);

endmodule

// File: rtl/powerup_manager.sv
// Powerup manager: turns a pixel-rate gift pickup into one frame-aligned
// activation, then times the effect in frames with a warning/blink phase.
// Pickup and startOfFrame are plain strobes with no back-pressure: a pickup
// is either latched on the cycle it is seen or dropped (paused, or a pickup
// is already pending this frame).
module powerup_manager
    import powerup_manager_pkg::*;
#(
    parameter int unsigned POWERUP_FRAMES = GIFT_POWERUP_FRAMES,
    parameter int unsigned WARN_FRAMES    = GIFT_WARN_FRAMES,
    parameter int unsigned BLINK_LOG2     = GIFT_BLINK_LOG2,
    parameter int unsigned CNT_WIDTH      = GIFT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 startOfFrame,
    input  logic                 pickup,
    input  logic                 powerup_type,
    output logic                 rapid_fire_active,
    output logic                 shield_active,
    output logic                 powerup_blink,
    output logic                 pickup_pulse,
    output logic [CNT_WIDTH-1:0] remaining_frames,
    output pu_state_t            o_state_dbg
);

    pu_state_t            r_state;
    pu_state_t            w_state_next;
    logic                 r_type;
    logic                 w_type_next;
    logic                 r_pending;
    logic                 r_pend_type;
    logic                 r_pulse;

    logic                 w_frame;
    logic                 w_pick_set;
    logic                 w_load;
    logic                 w_dec;
    logic [CNT_WIDTH-1:0] w_count;
    logic                 w_cnt_zero;
    logic                 w_dec_zero;
    logic                 w_dec_le_thresh;

    // Frame processing only happens on an enabled strobe; pause freezes all.
    assign w_frame    = startOfFrame & enable;
    // First qualifying pixel of a frame wins; later pixels are ignored.
    assign w_pick_set = pickup & enable & ~r_pending;

    frame_down_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .THRESHOLD (WARN_FRAMES)
    ) u_counter (
        .i_clk           (clk),
        .i_rst           (reset),
        .i_load          (w_load),
        .i_load_value    (CNT_WIDTH'(POWERUP_FRAMES)),
        .i_dec           (w_dec),
        .o_count         (w_count),
        .o_zero          (w_cnt_zero),
        .o_dec_zero      (w_dec_zero),
        .o_dec_le_thresh (w_dec_le_thresh)
    );

    // Next-state logic: a pending pickup replaces any running effect,
    // otherwise a running effect counts down through WARN to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_type_next  = r_type;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        if (w_frame) begin
            if (r_pending) begin
                w_load       = 1'b1;
                w_type_next  = r_pend_type;
                w_state_next = PU_ACTIVE;
            end else if (r_state != PU_IDLE && !w_cnt_zero) begin
                w_dec = 1'b1;
                if (w_dec_zero) begin
                    w_state_next = PU_IDLE;
                end else if (w_dec_le_thresh) begin
                    w_state_next = PU_WARN;
                end
            end
        end
    end

    // State, effect type and pickup strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PU_IDLE;
            r_type  <= POWERUP_TYPE_SHIELD;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_type  <= w_type_next;
            r_pulse <= w_frame & r_pending;
        end
    end

    // Pending latch: a new pickup sets it even on a strobe cycle, because
    // the strobe only consumes the pickup latched before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_pend_type <= POWERUP_TYPE_SHIELD;
        end else if (w_pick_set) begin
            r_pending   <= 1'b1;
            r_pend_type <= powerup_type;
        end else if (w_frame && r_pending) begin
            r_pending   <= 1'b0;
        end
    end

    assign rapid_fire_active = (r_state != PU_IDLE) & (r_type == POWERUP_TYPE_RAPID);
    assign shield_active     = (r_state != PU_IDLE) & (r_type == POWERUP_TYPE_SHIELD);
    assign powerup_blink     = (r_state == PU_ACTIVE) |
                               ((r_state == PU_WARN) & w_count[BLINK_LOG2]);
    assign pickup_pulse      = r_pulse;
    assign remaining_frames  = w_count;
    assign o_state_dbg       = r_state;

endmodule

// File: tb/tb_powerup_manager.sv
// Bench for powerup_manager: a cycle table of stimulus and expected outputs,
// then hand-written sequences for coincident strobe/pickup and async reset.
module tb_powerup_manager;
    import powerup_manager_pkg::*;

    localparam int CW = 10;
    localparam int PF = 10;
    localparam int WF = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sof = 1'b0;
    logic          pickup = 1'b0;
    logic          ptype = 1'b0;
    logic          rapid, shield, blink, pulse;
    logic [CW-1:0] rem;
    pu_state_t     state_dbg;

    int checks = 0;
    int errors = 0;

    powerup_manager #(
        .POWERUP_FRAMES (PF),
        .WARN_FRAMES    (WF),
        .BLINK_LOG2     (1),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .startOfFrame      (sof),
        .pickup            (pickup),
        .powerup_type      (ptype),
        .rapid_fire_active (rapid),
        .shield_active     (shield),
        .powerup_blink     (blink),
        .pickup_pulse      (pulse),
        .remaining_frames  (rem),
        .o_state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {rapid, shield, blink, pulse, remaining}.
    typedef struct {
        logic          en;
        logic          sof;
        logic          pick;
        logic          typ;
        logic [CW+3:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model used only while filling the table.
    int   m_rem;
    logic m_type;
    logic m_pend;
    logic m_ptype;

    task automatic push(input logic en, input logic s, input logic pk, input logic ty);
        vec_t          v;
        logic          apply;
        logic          b;
        logic [CW-1:0] r;
        apply = en & s & m_pend;
        if (apply) begin
            m_rem  = PF;
            m_type = m_ptype;
        end else if (en && s && m_rem != 0) begin
            m_rem = m_rem - 1;
        end
        if (en && pk && !m_pend) begin
            m_pend  = 1'b1;
            m_ptype = ty;
        end else if (apply) begin
            m_pend = 1'b0;
        end
        r = CW'(m_rem);
        if (m_rem == 0)       b = 1'b0;
        else if (m_rem > WF)  b = 1'b1;
        else                  b = r[1];
        v.en   = en;
        v.sof  = s;
        v.pick = pk;
        v.typ  = ty;
        v.exp  = {(m_rem != 0) & m_type, (m_rem != 0) & ~m_type, b, apply, r};
        vecs.push_back(v);
    endtask

    task automatic gap();
        push(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            push(1'b1, 1'b1, 1'b0, 1'b0);
            gap();
        end
    endtask

    task automatic check(input string name, input logic [CW+3:0] got, input logic [CW+3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rapid/shield/blink/pulse/rem=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     name, got[CW+3], got[CW+2], got[CW+1], got[CW], got[CW-1:0],
                     exp[CW+3], exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
        end
    endtask

    task automatic check_state(input string name, input pu_state_t exp);
        checks++;
        if (state_dbg !== exp) begin
            errors++;
            $display("FAIL %s: got state %0d expected %0d", name, state_dbg, exp);
        end
    endtask

    // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic en, input logic s, input logic pk, input logic ty);
        @(negedge clk);
        enable = en;
        sof    = s;
        pickup = pk;
        ptype  = ty;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW+3:0] outs();
        return {rapid, shield, blink, pulse, rem};
    endfunction

    initial begin
        m_rem = 0; m_type = 1'b0; m_pend = 1'b0; m_ptype = 1'b0;

        // Idle after reset.
        gap(); gap();
        // Pickup burst: 16 pixels, type 1 on the first, then 0.
        for (int i = 0; i < 16; i++) push(1'b1, 1'b0, 1'b1, (i == 0));
        gap();
        // Activation strobe, then the full expiry sequence.
        strobes(1);
        strobes(PF);
        // Replacement: rapid pickup, count down to 3, shield pickup.
        push(1'b1, 1'b0, 1'b1, 1'b1);
        strobes(1);
        strobes(7);
        push(1'b1, 1'b0, 1'b1, 1'b0);
        strobes(1);
        // Pause at remaining=6 with pickups and strobes during the pause.
        strobes(4);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 1'b0, 1'b1, i[0]);
            push(1'b0, 1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0, 1'b0);
        end
        gap();
        // Resume: 5 and onward to idle, with no pickup activated.
        strobes(6);

        // Reset phase.
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", outs(), '0);
        check_state("reset_state", PU_IDLE);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].sof, vecs[i].pick, vecs[i].typ);
            check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
        end

        // Coincident pickup and strobe while idle with nothing pending.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("coinc_same_strobe", outs(), '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("coinc_gap", outs(), '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("coinc_next_strobe", outs(), {1'b1, 1'b0, 1'b1, 1'b1, CW'(10)});
        check_state("coinc_state", PU_ACTIVE);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("coinc_pulse_drop", outs(), {1'b1, 1'b0, 1'b1, 1'b0, CW'(10)});

        // Bring remaining to 7, latch a pending pickup, then reset mid-cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_reset_rem7", outs(), {1'b1, 1'b0, 1'b1, 1'b0, CW'(7)});
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        pickup = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs(), '0);
        check_state("async_reset_state", PU_IDLE);
        @(negedge clk);
        reset = 1'b0;
        // The pending pickup must have been cleared by reset.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_reset_strobe", outs(), '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_idle", outs(), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_manager.md
Name: powerup_manager

Overview:
- Consumes the gift pickup event (player–gift collision on a visible gift) and the gift's powerup type bit.
- Converts the pixel-rate pickup into one frame-synchronous activation and runs a frame-counted powerup timer.
- Drives the active-effect flags to the player/shot logic, plus a HUD blink indicator and a one-cycle pickup pulse for score/sound.
- Sits directly downstream of the gift block, alongside the hit-detection collision bus.

Parameters:
- POWERUP_FRAMES, 600: frames an effect lasts after pickup (10 s at 60 Hz).
- WARN_FRAMES, 120: remaining-frame threshold at or below which the effect enters the warning (blink) phase; must be < POWERUP_FRAMES.
- BLINK_LOG2, 3: blink output follows bit BLINK_LOG2 of the remaining-frame counter, giving a toggle every 8 frames.
- CNT_WIDTH, 10: counter width; must satisfy 2^CNT_WIDTH > POWERUP_FRAMES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  game running; low = paused
- startOfFrame  in  1  one-cycle frame strobe
- pickup  in  1  per-pixel qualified collision: collision[COLLISION_PLAYER_GIFT] & giftDR
- powerup_type  in  1  gift type bit; 1 = rapid fire (red gift), 0 = shield (blue gift)
- rapid_fire_active  out  1  rapid-fire effect in force
- shield_active  out  1  shield effect in force
- powerup_blink  out  1  HUD indicator
- pickup_pulse  out  1  one-cycle strobe per accepted pickup
- remaining_frames  out  CNT_WIDTH  frames left in the current effect; 0 when idle

Behaviour:
- Reset, asynchronous and active-high, clears everything:
  - state = IDLE; all outputs 0; counter 0; pending latch 0; latched type 0.
  - Reset asserted mid-effect clears the effect immediately.
- States: IDLE, ACTIVE, WARN. All outputs are registered.
- Pending latch:
  - Any cycle with pickup & enable & !pending sets pending and captures powerup_type. First pixel wins; later pixels in the same frame are ignored.
  - pickup while enable = 0 is ignored.
- Frame processing, on startOfFrame & enable only:
  - If pending:
    - counter <= POWERUP_FRAMES; effect type <= latched type.
    - Any previous effect is replaced, not stacked, even when the type is the same.
    - pickup_pulse = 1 for exactly that cycle.
    - state <= ACTIVE; pending cleared.
  - Else if state != IDLE:
    - counter decrements by 1.
    - New value ≤ WARN_FRAMES and > 0: state <= WARN.
    - New value = 0: state <= IDLE, both effect flags cleared in the same cycle.
  - IDLE with no pending: nothing changes.
- Simultaneous pickup and startOfFrame in the same cycle:
  - The strobe consumes only the previously latched pending.
  - The new pickup sets pending for the next frame (pending_next = pickup-set, else cleared by strobe, else hold).
- Outputs:
  - rapid_fire_active = (state != IDLE) & type.
  - shield_active = (state != IDLE) & !type.
  - Both flags stay high through WARN.
  - powerup_blink: 0 in IDLE; 1 in ACTIVE; counter[BLINK_LOG2] in WARN.
  - remaining_frames = counter.
- Latency: pickup in frame N → flags assert in the cycle after the startOfFrame that begins frame N+1. Effect lasts exactly POWERUP_FRAMES frame strobes.
- enable low (pause):
  - Counter, state and outputs frozen.
  - startOfFrame ignored.
  - An existing pending is held and applied at the first enabled strobe.
- Counter never wraps: decrement only occurs from a nonzero value.

Decomposition:
- Shared parameters file: POWERUP_TYPE_SHIELD = 0, POWERUP_TYPE_RAPID = 1; the state enum type; default POWERUP_FRAMES / WARN_FRAMES values next to the existing GIFT_* constants.
- One natural sub-module: frame_down_counter.
  - Interface: load value, decrement-on-strobe, zero and ≤threshold flags, CNT_WIDTH-parameterised.
  - Reusable for the player invulnerability timer.

Test Plan (bench params POWERUP_FRAMES=10, WARN_FRAMES=4, BLINK_LOG2=1):
- Reset mid-effect:
  - Stimulus: reset pulse while rapid_fire_active=1, remaining_frames=7.
  - Response: all outputs 0 asynchronously, before the next clk edge.
- Pickup burst:
  - Stimulus: pickup high 16 cycles in frame 0 with type=1, type toggled to 0 after the first cycle.
  - Response: at frame-1 strobe, a single pickup_pulse, rapid_fire_active=1, shield_active=0, remaining_frames=10.
- Expiry timing:
  - Stimulus: frame strobes after the pickup above.
  - Response:
    - remaining 10→0 over 10 strobes.
    - WARN entered at remaining=4, powerup_blink = 0,1,1,0 sequence per counter bit 1.
    - Flags drop at the 10th strobe; remaining_frames=0.
- Replacement:
  - Stimulus: shield pickup at remaining=3.
  - Response: at next strobe, shield_active=1, rapid_fire_active=0, remaining_frames=10, powerup_blink=1.
- Coincident events:
  - Stimulus: pickup asserted in the same cycle as startOfFrame, no prior pending.
  - Response: no change that strobe; activation at the following strobe.
- Pause:
  - Stimulus: enable=0 for 5 strobes at remaining=6, with pickup pulses during the pause.
  - Response: remaining stays 6, no pending set; countdown resumes at 5 after enable=1.
